display_scan_ctrl: RTL and testbench

// - Output-side counterpart of the keypad column scanner: it scans a multiplexed 7-segment display
//   by driving one digit-select line at a time, where the keypad scanner senses one column at a time.
// - Holds the calculator's display digit buffer and shifts in keypad BCD codes qualified by KeyRead.
// - Accepts full-value loads of results from the calculator core; sits between keypad/core and display pins.

---
 rtl/calc_pkg.sv | 40 ++++
 rtl/seg7_decode.sv | 26 ++
 rtl/display_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: digit width, operator key codes, 7-segment patterns
// and the entry-mode state used by the display buffer.
package calc_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic [3:0] {
        KEY_ADD = 4'd10,
        KEY_SUB = 4'd11,
        KEY_MUL = 4'd12,
        KEY_DIV = 4'd13,
        KEY_EQ  = 4'd14,
        KEY_CLR = 4'd15
    } op_key_t;

    // Segment patterns ordered {g,f,e,d,c,b,a}, lit = 1
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'h40;

    // ST_RESULT: buffer holds a loaded result; the next digit starts a new number
    typedef enum logic {
        ST_TYPING = 1'b0,
        ST_RESULT = 1'b1
    } entry_state_t;

    function automatic logic is_digit_key(input logic [DIGIT_W-1:0] code);
        return code < DIGIT_W'(KEY_ADD);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to 7-segment decoder, active-high; codes above 9 show a minus sign.
module seg7_decode
    import calc_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_MINUS;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_MINUS;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Calculator display buffer with keypad digit entry, result loads and a
// multiplexed 7-segment scan with leading-zero blanking.
module display_scan_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned SCAN_DIV        = 1024,
    parameter int unsigned BLANK_CYC       = 2,
    parameter bit          SEG_ACT_HIGH    = 1'b1,
    parameter bit          DIGSEL_ACT_HIGH = 1'b1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [DIGIT_W-1:0]            BCDKey,
    input  logic                          KeyRead,
    input  logic                          clear,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
    output logic [SEG_W-1:0]              seg,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          full
);

    localparam int unsigned BUF_W = DIGIT_W * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    // XOR masks that also serve as the "all inactive" output values
    localparam logic [SEG_W-1:0]      SEG_OFF = SEG_ACT_HIGH ? '0 : '1;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = DIGSEL_ACT_HIGH ? '0 : '1;

    entry_state_t          state, state_next;
    logic [BUF_W-1:0]      digits, digits_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  key_q, key_edge_c;
    logic [IDX_W-1:0]      idx, idx_next;
    logic [PRE_W-1:0]      presc, presc_next;
    logic [DIGIT_W-1:0]    dig_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] nz_above;
    logic [DIGIT_W-1:0]    cur_digit;
    logic [SEG_W-1:0]      dec_seg_c, seg_next;
    logic [NUM_DIGITS-1:0] sel_next;
    logic                  slot_active, digit_blank;

    assign key_edge_c = KeyRead & ~key_q;

    // Buffer/count next state: clear beats load beats a key edge
    always_comb begin
        state_next  = state;
        digits_next = digits;
        cnt_next    = cnt;
        if (clear) begin
            state_next  = ST_TYPING;
            digits_next = '0;
            cnt_next    = '0;
        end else if (load) begin
            state_next  = ST_RESULT;
            digits_next = value_in;
            cnt_next    = '0;
        end else if (key_edge_c && is_digit_key(BCDKey)) begin
            if (state == ST_RESULT) begin
                state_next  = ST_TYPING;
                digits_next = BUF_W'(BCDKey);
                cnt_next    = CNT_W'(1);
            end else if (cnt != CNT_W'(NUM_DIGITS)) begin
                digits_next = {digits[BUF_W-DIGIT_W-1:0], BCDKey};
                cnt_next    = cnt + CNT_W'(1);
            end
        end
    end

    // Prescaler and digit index
    always_comb begin
        presc_next = presc + PRE_W'(1);
        idx_next   = idx;
        if (presc == PRE_W'(SCAN_DIV - 1)) begin
            presc_next = '0;
            idx_next   = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    // nz_above[i]: some digit at position i or higher is non-zero
    always_comb begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            dig_arr[i] = digits[i*DIGIT_W +: DIGIT_W];
        end
        nz_above = '0;
        nz_above[NUM_DIGITS-1] = |dig_arr[NUM_DIGITS-1];
        for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
            nz_above[i] = nz_above[i+1] | (|dig_arr[i]);
        end
    end

    assign cur_digit = dig_arr[idx];

    seg7_decode u_decode (
        .bcd   (cur_digit),
        .seg_c (dec_seg_c)
    );

    always_comb begin
        slot_active = (presc >= PRE_W'(BLANK_CYC));
        digit_blank = (idx != '0) && !nz_above[idx];
        seg_next    = (slot_active && !digit_blank) ? dec_seg_c : '0;
        sel_next    = slot_active ? (NUM_DIGITS'(1) << idx) : '0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_TYPING;
            digits    <= '0;
            cnt       <= '0;
            key_q     <= 1'b0;
            idx       <= '0;
            presc     <= '0;
            full      <= 1'b0;
            seg       <= SEG_OFF;
            digit_sel <= SEL_OFF;
        end else begin
            state     <= state_next;
            digits    <= digits_next;
            cnt       <= cnt_next;
            key_q     <= KeyRead;
            idx       <= idx_next;
            presc     <= presc_next;
            full      <= (cnt_next == CNT_W'(NUM_DIGITS));
            seg       <= seg_next ^ SEG_OFF;
            digit_sel <= sel_next ^ SEL_OFF;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: a default-polarity and an inverted-polarity
// instance share all inputs and are checked against the same hand-computed display.
module tb_display_scan_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  BCDKey = '0;
    logic        KeyRead = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  sel_a, sel_b;
    logic        full_a, full_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 CLK = ~CLK;

    display_scan_ctrl #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2),
        .SEG_ACT_HIGH(1'b1), .DIGSEL_ACT_HIGH(1'b1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .BCDKey(BCDKey), .KeyRead(KeyRead),
        .clear(clear), .load(load), .value_in(value_in),
        .seg(seg_a), .digit_sel(sel_a), .full(full_a)
    );

    display_scan_ctrl #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2),
        .SEG_ACT_HIGH(1'b0), .DIGSEL_ACT_HIGH(1'b0)
    ) dut_inv (
        .CLK(CLK), .RESET(RESET), .BCDKey(BCDKey), .KeyRead(KeyRead),
        .clear(clear), .load(load), .value_in(value_in),
        .seg(seg_b), .digit_sel(sel_b), .full(full_b)
    );

    // Rising edges since reset release; outputs show the scan position one edge earlier
    always @(posedge CLK or posedge RESET) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [6:0] eseg, input logic [3:0] esel);
        logic [6:0] iseg;
        logic [3:0] isel;
        iseg = ~eseg;
        isel = ~esel;
        chk({tag, " seg"},     32'(seg_a), 32'(eseg));
        chk({tag, " sel"},     32'(sel_a), 32'(esel));
        chk({tag, " seg_inv"}, 32'(seg_b), 32'(iseg));
        chk({tag, " sel_inv"}, 32'(sel_b), 32'(isel));
    endtask

    task automatic chk_full(input string tag, input logic exp);
        chk({tag, " full"},     32'(full_a), 32'(exp));
        chk({tag, " full_inv"}, 32'(full_b), 32'(exp));
    endtask

    // One whole scan period (4 digits x 8 cycles); e0 is the rightmost digit
    task automatic check_display(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                                 input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] es [4];
        logic [6:0] eseg;
        logic [3:0] esel;
        int p, d;
        es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
        for (int k = 0; k < 32; k++) begin
            @(negedge CLK);
            p = (cyc - 1) % 8;
            d = ((cyc - 1) / 8) % 4;
            esel = (p < 2) ? 4'b0000 : 4'(1 << d);
            eseg = (p < 2) ? 7'h00 : es[d];
            chk_out($sformatf("%s d%0d p%0d", tag, d, p), eseg, esel);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge CLK);
        BCDKey  = k;
        KeyRead = 1'b1;
        @(negedge CLK);
        KeyRead = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        bit seen;

        // Reset held: outputs inactive at both polarities
        repeat (3) @(negedge CLK);
        chk_out("in_reset", 7'h00, 4'b0000);
        chk_full("in_reset", 1'b0);
        RESET = 1'b0;
        check_display("empty", 7'h3F, 7'h00, 7'h00, 7'h00);
        chk_full("empty", 1'b0);

        // Reset mid-slot clears outputs without waiting for a clock edge
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge CLK);
            seen = (sel_a == 4'b0001);
        end
        chk("wait_sel0", 32'(seen), 32'(1));
        RESET = 1'b1;
        #1;
        chk_out("async_reset", 7'h00, 4'b0000);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        check_display("after_reset", 7'h3F, 7'h00, 7'h00, 7'h00);

        // Four digits fill the buffer; a fifth is ignored
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk_full("four_keys", 1'b1);
        check_display("1234", 7'h66, 7'h4F, 7'h5B, 7'h06);
        press(4'd5);
        check_display("fifth_key", 7'h66, 7'h4F, 7'h5B, 7'h06);
        chk_full("fifth_key", 1'b1);

        // Clear, then a key held for 500 cycles enters one digit
        @(negedge CLK); clear = 1'b1;
        @(negedge CLK); clear = 1'b0;
        @(negedge CLK);
        chk_full("clear", 1'b0);
        BCDKey = 4'd6; KeyRead = 1'b1;
        repeat (500) @(negedge CLK);
        KeyRead = 1'b0;
        @(negedge CLK);
        check_display("held6", 7'h7D, 7'h00, 7'h00, 7'h00);
        chk_full("held6", 1'b0);

        // Operator key leaves the buffer alone
        press(4'd11);
        check_display("op_key", 7'h7D, 7'h00, 7'h00, 7'h00);

        // Fill to "6123", then clear coinciding with a key edge of 7
        press(4'd1); press(4'd2); press(4'd3);
        chk_full("6123", 1'b1);
        check_display("6123", 7'h4F, 7'h5B, 7'h06, 7'h7D);
        @(negedge CLK); clear = 1'b1; BCDKey = 4'd7; KeyRead = 1'b1;
        @(negedge CLK); clear = 1'b0;
        @(negedge CLK); KeyRead = 1'b0;
        @(negedge CLK);
        chk_full("clear_key", 1'b0);
        check_display("clear_key", 7'h3F, 7'h00, 7'h00, 7'h00);

        // Loaded result, then a digit starts a fresh number
        @(negedge CLK); load = 1'b1; value_in = 16'h0042;
        @(negedge CLK); load = 1'b0;
        check_display("load42", 7'h5B, 7'h66, 7'h00, 7'h00);
        chk_full("load42", 1'b0);
        press(4'd9);
        check_display("fresh9", 7'h6F, 7'h00, 7'h00, 7'h00);
        chk_full("fresh9", 1'b0);

        // Load wins over a simultaneous key edge; inner zero stays lit
        @(negedge CLK); load = 1'b1; value_in = 16'h1305; BCDKey = 4'd8; KeyRead = 1'b1;
        @(negedge CLK); load = 1'b0;
        @(negedge CLK); KeyRead = 1'b0;
        check_display("load1305", 7'h6D, 7'h3F, 7'h4F, 7'h06);

        // Non-BCD loaded digit shows a minus sign
        @(negedge CLK); load = 1'b1; value_in = 16'h00A0;
        @(negedge CLK); load = 1'b0;
        check_display("loadA0", 7'h3F, 7'h40, 7'h00, 7'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

endmodule
